// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// dsp_pkg: shared CIC decimator types, width helper and PDM mapping constants.
// Rev 1.0
// ============================================================================
package dsp_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMB    = 2'd2,
    S_PUSH    = 2'd3
  } cic_state_t;

  // Two-bit signed encodings of the PDM symbols, sign-extended by the user.
  localparam logic [1:0] c_PDM_POS = 2'b01;
  localparam logic [1:0] c_PDM_NEG = 2'b11;

  function automatic int acc_width(input int order, input int decim);
    return order * $clog2(decim) + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_integrator_chain.sv
`default_nettype none
// ============================================================================
// cic_integrator_chain: ORDER cascaded wrapping integrators, all stepping on en.
// Rev 1.0
// ============================================================================
module cic_integrator_chain #(
  parameter int ORDER = 4,
  parameter int ACC_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] y
);

  logic [ACC_W-1:0] r_integ [ORDER];

  // Every stage adds the previous stage's old value, forming a pipelined cascade.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ORDER; i++) r_integ[i] <= '0;
    end else if (en) begin
      r_integ[0] <= r_integ[0] + x;
      for (int i = 1; i < ORDER; i++) r_integ[i] <= r_integ[i] + r_integ[i-1];
    end
  end

  assign y = r_integ[ORDER-1];

endmodule
`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// pdm_cic_decimator: PDM-to-PCM CIC decimator pushing samples into a sync FIFO.
// Rev 1.0
// ============================================================================
module pdm_cic_decimator
  import dsp_pkg::*;
#(
  parameter int ORDER = 4,
  parameter int DECIM = 32,
  parameter int WIDTH = 18,
  parameter int ACC_W = acc_width(ORDER, DECIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_en,
  input  logic             pdm_bit,
  input  logic             full,
  output logic             wr_en,
  output logic [WIDTH-1:0] d_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int K_W   = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [K_W-1:0]   c_K_LAST   = K_W'(ORDER - 1);

  cic_state_t       r_state;
  cic_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_dec_cnt;
  logic             r_tick;
  logic             w_tick;
  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_integ;
  logic [ACC_W-1:0] w_diff;
  logic [ACC_W-1:0] r_snap;
  logic [ACC_W-1:0] r_dly [ORDER];
  logic [K_W-1:0]   r_k;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_sample;
  logic             r_ovf;

  assign w_x = pdm_bit ? {{(ACC_W-2){c_PDM_POS[1]}}, c_PDM_POS}
                       : {{(ACC_W-2){c_PDM_NEG[1]}}, c_PDM_NEG};

  cic_integrator_chain #(
    .ORDER (ORDER),
    .ACC_W (ACC_W)
  ) u_integ (
    .clk (clk),
    .rst (rst),
    .en  (pdm_en),
    .x   (w_x),
    .y   (w_integ)
  );

  assign w_tick = pdm_en && (r_dec_cnt == c_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_cnt <= '0;
    end else if (pdm_en) begin
      r_dec_cnt <= (r_dec_cnt == c_CNT_LAST) ? '0 : r_dec_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (r_tick) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_COMB;
      S_COMB:    if (r_k == c_K_LAST) w_state_nxt = S_PUSH;
      S_PUSH:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // One subtractor serves every comb stage; r_k selects the stage delay.
  assign w_diff   = r_snap - r_dly[r_k];
  assign w_sample = r_snap[ACC_W-1 -: WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= 1'b0;
      r_snap <= '0;
      r_k    <= '0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < ORDER; i++) r_dly[i] <= '0;
    end else begin
      r_tick <= w_tick && !busy;
      if (w_tick && busy) r_ovf <= 1'b1;
      case (r_state)
        S_CAPTURE: begin
          r_snap <= w_integ;
          r_k    <= '0;
        end
        S_COMB: begin
          r_snap     <= w_diff;
          r_dly[r_k] <= r_snap;
          r_k        <= r_k + K_W'(1);
        end
        S_PUSH: begin
          if (full) r_ovf  <= 1'b1;
          else      r_dout <= w_sample;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign wr_en    = (r_state == S_PUSH) && !full;
  assign d_out    = (r_state == S_PUSH) ? w_sample : r_dout;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// tb_pdm_cic_decimator: directed stimulus with a queue-based write scoreboard.
// Rev 1.0
// ============================================================================
module tb_pdm_cic_decimator;

  localparam int ORDER = 4;
  localparam int DECIM = 32;
  localparam int WIDTH = 18;
  localparam int LAT   = ORDER + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pdm_en = 1'b0;
  logic             pdm_bit = 1'b0;
  logic             full = 1'b0;
  logic             wr_en;
  logic [WIDTH-1:0] d_out;
  logic             overflow;
  logic             busy;

  logic             pdm_en2 = 1'b0;
  logic             pdm_bit2 = 1'b1;
  logic             full2 = 1'b0;
  logic             wr_en2;
  logic [WIDTH-1:0] d_out2;
  logic             overflow2;
  logic             busy2;

  always #5 clk = ~clk;

  pdm_cic_decimator #(
    .ORDER (ORDER),
    .DECIM (DECIM),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pdm_en   (pdm_en),
    .pdm_bit  (pdm_bit),
    .full     (full),
    .wr_en    (wr_en),
    .d_out    (d_out),
    .overflow (overflow),
    .busy     (busy)
  );

  pdm_cic_decimator #(
    .ORDER (4),
    .DECIM (2),
    .WIDTH (18),
    .ACC_W (22)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .pdm_en   (pdm_en2),
    .pdm_bit  (pdm_bit2),
    .full     (full2),
    .wr_en    (wr_en2),
    .d_out    (d_out2),
    .overflow (overflow2),
    .busy     (busy2)
  );

  typedef struct {
    logic [WIDTH-1:0] val;
    bit               care;
    int unsigned      cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          n_en = 0;
  int          writes2 = 0;
  logic        prev_wr = 1'b0;
  logic        alt = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      check("wr_en_single_cycle", 32'(prev_wr), 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got write of %0h expected no write", d_out);
      end else begin
        mon_e = sb.pop_front();
        check("write_cycle", 32'(cyc + 1), 32'(mon_e.cyc));
        if (mon_e.care) check("d_out", 32'(d_out), 32'(mon_e.val));
      end
    end
    prev_wr = wr_en;
    if (wr_en2 === 1'b1) writes2++;
  end

  task automatic send(input logic b, input bit care_v, input logic [WIDTH-1:0] v, input bit drop);
    @(negedge clk);
    pdm_bit = b;
    pdm_en  = 1'b1;
    n_en++;
    full = 1'b0;
    if (n_en % DECIM == 0) begin
      if (drop) full = 1'b1;
      else sb.push_back('{val: v, care: care_v, cyc: cyc + 1 + LAT});
    end
    @(negedge clk);
    pdm_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // mode: 0 = all zeros, 1 = all ones, 2 = alternating starting from 1.
  task automatic run_phase(input int mode, input int nticks, input logic [WIDTH-1:0] v,
                           input int first_care, input bit drop_first);
    logic b;
    for (int t = 1; t <= nticks; t++) begin
      for (int i = 0; i < DECIM; i++) begin
        if (mode == 2) begin
          b   = alt;
          alt = ~alt;
        end else begin
          b = (mode == 1);
        end
        send(b, t >= first_care, v, drop_first && (t == 1));
      end
    end
  endtask

  initial begin
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_phase(1, 6, 18'h10000, 5, 1'b0);
    run_phase(0, 6, 18'h30000, 5, 1'b0);
    run_phase(2, 6, 18'h00000, 5, 1'b0);

    check("overflow_before_full", 32'(overflow), 32'd0);
    run_phase(2, 2, 18'h00000, 2, 1'b1);
    check("overflow_after_full", 32'(overflow), 32'd1);

    run_phase(1, 5, 18'h10000, 5, 1'b0);
    repeat (3) @(negedge clk);
    check("d_out_hold", 32'(d_out), 32'h10000);
    check("overflow_sticky", 32'(overflow), 32'd1);

    for (int i = 0; i < DECIM - 1; i++) send(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    pdm_bit = 1'b1;
    pdm_en  = 1'b1;
    @(negedge clk);
    pdm_en = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_in_comb", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_d_out", 32'(d_out), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    n_en = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_phase(1, 1, '0, 99, 1'b0);
    repeat (LAT + 4) @(negedge clk);
    check("queue_drained", 32'(sb.size()), 32'd0);

    check("ovf2_initial", 32'(overflow2), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pdm_en2 = 1'b1;
      @(negedge clk);
      pdm_en2 = 1'b0;
    end
    repeat (12) @(negedge clk);
    check("decim2_writes", 32'(writes2), 32'd4);
    check("decim2_overflow", 32'(overflow2), 32'd1);
    check("decim2_busy_idle", 32'(busy2), 32'd0);
    check("decim2_d_out_nonzero", 32'(d_out2 != '0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 Parameter ORDER, default 4: number of CIC integrator stages and number of comb stages.
REQ-002 Parameter DECIM, default 32: decimation ratio; must be a power of two, at least 2.
REQ-003 Parameter WIDTH, default 18: output sample width, matching the downstream sync FIFO.
REQ-004 Parameter ACC_W, default ORDER*log2(DECIM)+2 (22): integrator and comb width in bits, two's complement.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 pdm_en  in  1  one-clk strobe marking a valid pdm_bit; minimum spacing ORDER+3 clks.
REQ-008 pdm_bit  in  1  PDM microphone bit; sampled only when pdm_en=1.
REQ-009 full  in  1  FIFO full flag from the downstream sync FIFO.
REQ-010 wr_en  out  1  one-clk write strobe to the FIFO.
REQ-011 d_out  out  WIDTH  decimated sample, signed; valid while wr_en=1.
REQ-012 overflow  out  1  sticky flag: a sample was dropped because full=1, or a tick was missed.
REQ-013 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Input mapping: pdm_bit=1 gives +1 and pdm_bit=0 gives -1, both sign-extended to ACC_W.
REQ-015 On each pdm_en, all ORDER integrators update in the same clk: integ[0]+=x and integ[k]+=integ[k-1] (old value), with modulo-2^ACC_W wrap and no saturation.
REQ-016 Decimation counter: dec_cnt increments on each pdm_en and wraps from DECIM-1 to 0; the wrapping pdm_en is the decimation "tick".
REQ-017 FSM states are IDLE, CAPTURE, COMB, PUSH.
REQ-018 IDLE to CAPTURE: on the clk after a tick.
REQ-019 CAPTURE: snap is loaded with integ[ORDER-1] and stage index k is cleared to 0; next state is COMB.
REQ-020 COMB: each clk, snap is replaced by snap-dly[k], dly[k] is replaced by the old snap, and k increments; after ORDER clks the next state is PUSH.
REQ-021 PUSH: if full=0, wr_en=1 and d_out=snap[ACC_W-1:ACC_W-WIDTH]; if full=1, wr_en stays 0, the sample is dropped and overflow is set; next state is IDLE.
REQ-022 Latency: wr_en is asserted exactly ORDER+3 clks after the clk in which the tick pdm_en was sampled.
REQ-023 wr_en is never high for more than one consecutive clk, and is high only in PUSH.
REQ-024 A tick that arrives while busy=1 sets overflow, and that decimation output is skipped; integrators still update.
REQ-025 Comb subtraction wraps modulo 2^ACC_W.
REQ-026 The first ORDER outputs after reset are transient; they are still written to the FIFO.
REQ-027 d_out holds its last written value between writes.

Reset
REQ-028 While rst=1, asynchronously: state=IDLE, wr_en=0, d_out=0, overflow=0, busy=0, dec_cnt=0, and all integ, dly and snap registers are 0.
REQ-029 Reset asserted mid-operation, in any FSM state, aborts the operation with no partial write.
REQ-030 The first tick after reset deasserts occurs on the DECIM-th pdm_en.
REQ-031 overflow clears only on reset.

Structure
REQ-032 Shared package dsp_pkg holds the FSM state enumeration, the ACC_W derivation function and the PDM-to-signed mapping constants.
REQ-033 Sub-module cic_integrator_chain (parameters ORDER and ACC_W; ports clk, rst, en, x, y) holds the integrator cascade.
REQ-034 The comb section and FSM are inline, using a single shared ACC_W subtractor.

Verification
REQ-035 Constant pdm_bit=1, pdm_en every 8 clks, full=0: from the 5th output onward, d_out=+65536 (0x10000) on every wr_en.
REQ-036 Constant pdm_bit=0: steady-state d_out=-65536 (0x30000 in 18-bit two's complement).
REQ-037 Alternating 1,0,1,0 pattern: steady-state d_out=0, with wr_en every 32 pdm_en strobes.
REQ-038 Hold full=1 across one PUSH: no wr_en, overflow=1, the next output (full=0) is written normally.
REQ-039 pdm_en with spacing 2 clks at DECIM=2: tick during busy gives overflow=1 and a skipped output.
REQ-040 Assert rst while in COMB: wr_en stays 0, all outputs return to 0 immediately, and the next wr_en follows the DECIM-th pdm_en after release.
